// File: rtl/mul_compressor_pipe.sv
// Pipelined WIDTH x WIDTH multiplier (signed/unsigned) with tag sideband; the 3:2 compressor layers are spread over PIPE_DEPTH stages and the last stage does the carry-propagate add.
// Latency is PIPE_DEPTH cycles and bubbles collapse under out_ready backpressure. Define MUL_COMPRESSOR_PIPE_ACC_EN to add the result accumulator.
module mul_compressor_pipe #(
    parameter int WIDTH      = 9,
    parameter int PIPE_DEPTH = 5,
    parameter int TAG_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    input  logic [TAG_W-1:0]     in_tag,
`ifdef MUL_COMPRESSOR_PIPE_ACC_EN
    input  logic                 in_acc_clr,
    output logic [2*WIDTH+7:0]   out_acc,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int PW = 2 * WIDTH;
    localparam int NR = 2 * WIDTH;

    typedef logic [NR-1:0][PW-1:0] heap_t;

    function automatic int count_layers(input int n);
        int m;
        int c;
        m = n;
        c = 0;
        while (m > 2) begin
            m = 2 * (m / 3) + (m % 3);
            c++;
        end
        return c;
    endfunction

    localparam int NL = count_layers(NR);

    function automatic int stage_layers(input int s);
        return (NL * (s + 1)) / PIPE_DEPTH - (NL * s) / PIPE_DEPTH;
    endfunction

    // Operands are extended to 2*WIDTH, so the modular product is correct for both signednesses.
    function automatic heap_t pp_gen(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic sgn);
        logic [PW-1:0] a_x;
        logic [PW-1:0] b_x;
        heap_t         h;
        a_x = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        b_x = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        for (int i = 0; i < NR; i++) begin
            h[i] = b_x[i] ? (a_x << i) : '0;
        end
        return h;
    endfunction

    // Live rows always sit at the bottom of the heap, so each layer packs its outputs there too.
    function automatic heap_t csa_layer(input heap_t h);
        heap_t o;
        o = '0;
        for (int g = 0; g < NR / 3; g++) begin
            o[2*g]   = h[3*g] ^ h[3*g+1] ^ h[3*g+2];
            o[2*g+1] = ((h[3*g] & h[3*g+1]) | (h[3*g] & h[3*g+2]) | (h[3*g+1] & h[3*g+2])) << 1;
        end
        for (int k = 0; k < NR % 3; k++) begin
            o[2*(NR/3)+k] = h[3*(NR/3)+k];
        end
        return o;
    endfunction

    function automatic heap_t reduce(input heap_t h_in, input int n);
        heap_t h;
        h = h_in;
        for (int l = 0; l < NL; l++) begin
            if (l < n) h = csa_layer(h);
        end
        return h;
    endfunction

    logic [PIPE_DEPTH-1:0] r_vld;
    logic [TAG_W-1:0]      r_tag [PIPE_DEPTH];
    logic [PW-1:0]         r_prod;
    logic [PIPE_DEPTH-1:0] w_load;
    logic [PIPE_DEPTH-1:0] w_in_vld;
    logic [TAG_W-1:0]      w_in_tag [PIPE_DEPTH];
    heap_t                 w_src [PIPE_DEPTH];
    heap_t                 w_red [PIPE_DEPTH];
    logic [PW-1:0]         w_sum;

    always_comb begin
        w_in_vld[0] = in_valid;
        w_in_tag[0] = in_tag;
        for (int s = 1; s < PIPE_DEPTH; s++) begin
            w_in_vld[s] = r_vld[s-1];
            w_in_tag[s] = r_tag[s-1];
        end
    end

    always_comb begin
        logic nxt;
        nxt    = out_ready;
        w_load = '0;
        for (int s = PIPE_DEPTH - 1; s >= 0; s--) begin
            w_load[s] = ~r_vld[s] | nxt;
            nxt       = w_load[s];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int s = 0; s < PIPE_DEPTH; s++) r_tag[s] <= '0;
        end else begin
            for (int s = 0; s < PIPE_DEPTH; s++) begin
                if (w_load[s]) begin
                    r_vld[s] <= w_in_vld[s];
                    if (w_in_vld[s]) r_tag[s] <= w_in_tag[s];
                end
            end
        end
    end

    assign w_src[0] = pp_gen(in_a, in_b, in_signed);

    for (genvar s = 0; s < PIPE_DEPTH; s++) begin : g_stage
        localparam int LS = stage_layers(s);
        assign w_red[s] = reduce(w_src[s], LS);
        if (s < PIPE_DEPTH - 1) begin : g_csa
            heap_t r_heap;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                         r_heap <= '0;
                else if (w_load[s] && w_in_vld[s])  r_heap <= w_red[s];
            end
            assign w_src[s+1] = r_heap;
        end
    end

    assign w_sum = w_red[PIPE_DEPTH-1][0] + w_red[PIPE_DEPTH-1][1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                               r_prod <= '0;
        else if (w_load[PIPE_DEPTH-1] && w_in_vld[PIPE_DEPTH-1])  r_prod <= w_sum;
    end

`ifdef MUL_COMPRESSOR_PIPE_ACC_EN
    logic [PIPE_DEPTH-1:0] r_sgn;
    logic [PIPE_DEPTH-1:0] r_clr;
    logic [PIPE_DEPTH-1:0] w_in_sgn;
    logic [PIPE_DEPTH-1:0] w_in_clr;
    logic [PW+7:0]         r_acc;

    always_comb begin
        w_in_sgn[0] = in_signed;
        w_in_clr[0] = in_acc_clr;
        for (int s = 1; s < PIPE_DEPTH; s++) begin
            w_in_sgn[s] = r_sgn[s-1];
            w_in_clr[s] = r_clr[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sgn <= '0;
            r_clr <= '0;
            r_acc <= '0;
        end else begin
            for (int s = 0; s < PIPE_DEPTH; s++) begin
                if (w_load[s] && w_in_vld[s]) begin
                    r_sgn[s] <= w_in_sgn[s];
                    r_clr[s] <= w_in_clr[s];
                end
            end
            // Unsigned products are zero-extended; signed ones carry their sign into the guard bits.
            if (w_load[PIPE_DEPTH-1] && w_in_vld[PIPE_DEPTH-1])
                r_acc <= (w_in_clr[PIPE_DEPTH-1] ? '0 : r_acc)
                       + (w_in_sgn[PIPE_DEPTH-1] ? {{8{w_sum[PW-1]}}, w_sum} : {8'b0, w_sum});
        end
    end

    assign out_acc = r_acc;
`endif

    assign in_ready  = w_load[0];
    assign out_valid = r_vld[PIPE_DEPTH-1];
    assign out_prod  = r_prod;
    assign out_tag   = r_tag[PIPE_DEPTH-1];

endmodule

// File: tb/tb_mul_compressor_pipe.sv
// Scoreboard bench for mul_compressor_pipe: accepted operations are modelled with plain integer
// multiplication and checked in order by an independent output monitor.
module tb_mul_compressor_pipe;
    localparam int W  = 9;
    localparam int D  = 5;
    localparam int T  = 4;
    localparam int AW = 2 * W + 8;

    typedef struct {
        logic [2*W-1:0] prod;
        logic [T-1:0]   tag;
        logic [AW-1:0]  acc;
        int             cyc;
        bit             exact;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic           in_signed = 1'b0;
    logic [T-1:0]   in_tag = '0;
    logic           acc_clr = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] out_prod;
    logic [T-1:0]   out_tag;
`ifdef MUL_COMPRESSOR_PIPE_ACC_EN
    logic [AW-1:0]  out_acc;
`endif

    exp_t          q[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            n_acc = 0;
    int            cyc = 0;
    bit            exact_mode = 1'b0;
    bit            rand_phase = 1'b0;
    logic [AW-1:0] acc_model = '0;

    mul_compressor_pipe #(.WIDTH(W), .PIPE_DEPTH(D), .TAG_W(T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .in_tag    (in_tag),
`ifdef MUL_COMPRESSOR_PIPE_ACC_EN
        .in_acc_clr(acc_clr),
        .out_acc   (out_acc),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
        longint     sa;
        longint     sb;
        logic [63:0] p;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        p  = 64'(sa * sb);
        return p[2*W-1:0];
    endfunction

    // Reference: record every accepted operation with its expected product and running sum.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            exp_t          e;
            logic [AW-1:0] pe;
            e.prod = ref_mul(in_a, in_b, in_signed);
            e.tag  = in_tag;
            pe     = in_signed ? {{8{e.prod[2*W-1]}}, e.prod} : {8'b0, e.prod};
            acc_model = (acc_clr ? '0 : acc_model) + pe;
            e.acc   = acc_model;
            e.cyc   = cyc;
            e.exact = exact_mode;
            q.push_back(e);
            n_acc++;
        end
    end

    // Monitor: whatever is presented must match the oldest outstanding operation, held or not.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", 64'(out_valid), 64'(0));
            end else begin
                chk("out_prod", 64'(out_prod), 64'(q[0].prod));
                chk("out_tag", 64'(out_tag), 64'(q[0].tag));
`ifdef MUL_COMPRESSOR_PIPE_ACC_EN
                chk("out_acc", 64'(out_acc), 64'(q[0].acc));
`endif
                if (out_ready) begin
                    if (q[0].exact) chk("latency", 64'(cyc - q[0].cyc), 64'(D));
                    else            chk("latency_min", 64'((cyc - q[0].cyc) >= D), 64'(1));
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [T-1:0] tag, input logic clr);
        bit took;
        took      = 1'b0;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_tag    = tag;
        acc_clr   = clr;
        in_valid  = 1'b1;
        for (int k = 0; k < 2000 && !took; k++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
        end
        if (!took) chk("send_timeout", 64'(took), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 3000 && q.size() != 0; k++) wait_cyc(1);
        chk("drain", 64'(q.size()), 64'(0));
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b1, {(W-1){1'b0}}};
            default: v = W'($urandom_range(0, (1 << W) - 1));
        endcase
        return v;
    endfunction

    initial begin
        int base;
        wait_cyc(3);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_prod", 64'(out_prod), 64'(0));
        chk("rst_out_tag", 64'(out_tag), 64'(0));
        rst_n = 1'b1;
        wait_cyc(1);
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));

        exact_mode = 1'b1;
        send(9'h1FF, 9'h1FF, 1'b0, 4'd3, 1'b1);
        drain();
        send(9'h100, 9'h0FF, 1'b1, 4'd5, 1'b0);
        send(9'h100, 9'h0FF, 1'b0, 4'd6, 1'b0);
        send(9'h100, 9'h100, 1'b1, 4'd7, 1'b0);
        send(9'h1FF, 9'h1FF, 1'b1, 4'd8, 1'b0);
        send(9'h000, 9'h1FF, 1'b1, 4'd9, 1'b0);
        send(9'h0FF, 9'h101, 1'b1, 4'd10, 1'b0);
        drain();
        exact_mode = 1'b0;

        // Backpressure: five fill the pipe, the rest wait, order and values preserved.
        out_ready = 1'b0;
        base = n_acc;
        fork
            for (int t = 0; t < 16; t++) send(pick(), pick(), 1'($urandom_range(0, 1)), T'(t), 1'b0);
            begin
                wait_cyc(10);
                chk("accepts_while_stalled", 64'(n_acc - base), 64'(D));
                chk("in_ready_when_full", 64'(in_ready), 64'(0));
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-flight discards everything in the pipe.
        send(9'd11, 9'd12, 1'b0, 4'd1, 1'b0);
        send(9'd13, 9'd14, 1'b0, 4'd2, 1'b0);
        send(9'd15, 9'd16, 1'b0, 4'd3, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_out_prod", 64'(out_prod), 64'(0));
        q.delete();
        acc_model = '0;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(12);
        exact_mode = 1'b1;
        send(9'd2, 9'd3, 1'b0, 4'd4, 1'b1);
        drain();
        exact_mode = 1'b0;

`ifdef MUL_COMPRESSOR_PIPE_ACC_EN
        send(9'd3, 9'd4, 1'b0, 4'd1, 1'b1);
        send(9'd5, 9'd6, 1'b0, 4'd2, 1'b0);
        drain();
`endif

        rand_phase = 1'b1;
        fork
            begin
                for (int i = 0; i < 3000; i++) begin
                    if ($urandom_range(0, 3) == 0) wait_cyc($urandom_range(1, 3));
                    send(pick(), pick(), 1'($urandom_range(0, 1)), T'($urandom_range(0, (1 << T) - 1)),
                         1'($urandom_range(0, 7) == 0));
                end
                rand_phase = 1'b0;
            end
            while (rand_phase) begin
                out_ready = ($urandom_range(0, 9) < 7);
                wait_cyc(1);
            end
        join
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected to finish earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mul_compressor_pipe.md
MUL_COMPRESSOR_PIPE -- requirements
Module: mul_compressor_pipe

Interface
REQ-001 Parameter WIDTH, default 9, operand width in bits; legal range 4..32.
REQ-002 Parameter PIPE_DEPTH, default 5, number of register stages from input to output; legal range 1..8.
REQ-003 Parameter TAG_W, default 4, width of a sideband tag carried with each operation.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operand pair offered.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 in_a, in_b  input  WIDTH each  multiplicand and multiplier.
REQ-009 in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-010 in_tag  input  TAG_W  sideband tag, returned unchanged with the result.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_prod  output  2*WIDTH  product.
REQ-014 out_tag  output  TAG_W  tag of the product on out_prod.

Function
REQ-015 An operation SHALL be accepted on any rising edge where in_valid and in_ready are both 1; a result SHALL be consumed on any rising edge where out_valid and out_ready are both 1.
REQ-016 out_prod SHALL equal in_a*in_b exactly, modulo 2^(2*WIDTH), interpreted per in_signed as sampled at acceptance.
REQ-017 The partial-product column heap SHALL be reduced by counter/compressor stages distributed across the PIPE_DEPTH register boundaries, with the final carry-propagate addition in the last stage; GPC choice is free provided REQ-016 holds.
REQ-018 With out_ready held 1, latency from acceptance to out_valid SHALL be exactly PIPE_DEPTH cycles, and throughput SHALL be one operation per cycle.
REQ-019 Each stage SHALL hold a valid bit; a stage SHALL advance when the next stage is empty or advancing (bubble collapsing); in_ready SHALL be 1 when stage 0 is empty or advancing.
REQ-020 Under backpressure the pipeline SHALL hold up to PIPE_DEPTH operations with no loss, duplication or reordering, and out_prod/out_tag SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 Simultaneous accept and consume on a full pipeline SHALL be permitted in the same cycle.
REQ-022 in_a, in_b, in_signed and in_tag SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-023 On rst_n=0, all stage valid bits SHALL clear immediately; out_valid=0, out_prod=0, out_tag=0, and in_ready SHALL be 1 from the first cycle after release.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight operations; none SHALL appear on the output after release.

Configuration
REQ-025 With macro MUL_COMPRESSOR_PIPE_ACC_EN defined, the block SHALL add input in_acc_clr (1, sampled with operands), output out_acc (2*WIDTH+8), and an accumulator updated in the last stage when a result is produced: out_acc = (clr ? 0 : previous out_acc) + sign-extended product.
REQ-026 With MUL_COMPRESSOR_PIPE_ACC_EN defined, out_acc SHALL reset to 0, SHALL wrap modulo 2^(2*WIDTH+8), and SHALL hold stable under backpressure together with out_prod.
REQ-027 Without MUL_COMPRESSOR_PIPE_ACC_EN, in_acc_clr and out_acc SHALL not exist and no accumulator logic SHALL be built.

Verification
REQ-028 WIDTH=9, PIPE_DEPTH=5, unsigned 511*511, tag 3, out_ready=1 -> out_valid 5 cycles after accept, out_prod=0x3FC01, out_tag=3.
REQ-029 Signed 0x100 (-256) * 0x0FF (255) -> out_prod=0x30100 (-65280 in 18 bits); same operands unsigned -> 0x0FF00.
REQ-030 Back-to-back accepts with tags 0..15 and out_ready=0 for 10 cycles -> in_ready drops after 5 accepts; on release results emerge in tag order 0..15, each correct, none lost.
REQ-031 Three operations in flight, rst_n pulsed low mid-cycle -> out_valid=0 immediately; no stale result appears after release; the next operation 2*3 returns 6.
REQ-032 Random signed/unsigned operands, random in_valid/out_ready, 10^5 operations at WIDTH 4, 9, 16 and PIPE_DEPTH 1, 5, 8 -> every out_prod matches the reference model.
REQ-033 MUL_COMPRESSOR_PIPE_ACC_EN defined, 3*4 with clr=1 then 5*6 with clr=0 -> out_acc=12, then 42.
